// File: rtl/reg_file_sb.sv
// Clocked register file with a synchronous write port, bypassed combinational read ports and a busy scoreboard.
// Optional macro REG_ZERO_EN hardwires register 0 to zero and ignores claims of it.
module reg_file_sb #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 4,
  parameter int          NUM_RD     = 2,
  parameter logic [3:0]  INHIBIT_OP = 4'b1111
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [3:0]                 opcode,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       claim_en,
  input  logic [ADDR_W-1:0]          claim_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       any_busy,
  output logic [15:0]                wr_count
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [15:0]       count;
  logic              wr_fire;
  logic              claim_fire;
  logic              wr_store;
  logic              claim_set;

  // Gating with rst_n keeps the bypass paths quiet while reset is held.
  assign wr_fire    = rst_n && wr_en    && (opcode != INHIBIT_OP);
  assign claim_fire = rst_n && claim_en && (opcode != INHIBIT_OP);

`ifdef REG_ZERO_EN
  assign wr_store  = wr_fire    && (wr_addr    != '0);
  assign claim_set = claim_fire && (claim_addr != '0);
`else
  assign wr_store  = wr_fire;
  assign claim_set = claim_fire;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_store) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Claim is applied after the clear so a same-address claim keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_fire)   busy_nxt[wr_addr]    = 1'b0;
    if (claim_set) busy_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy <= busy_nxt;
      if (wr_fire) count <= count + 16'd1;
    end
  end

  assign any_busy = |busy;
  assign wr_count = count;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra  = rd_addr[i*ADDR_W +: ADDR_W];
    assign hit = wr_fire && (wr_addr == ra);
`ifdef REG_ZERO_EN
    assign rd_data[i*DATA_W +: DATA_W] = (ra == '0) ? '0 : (hit ? wr_data : mem[ra]);
`else
    assign rd_data[i*DATA_W +: DATA_W] = hit ? wr_data : mem[ra];
`endif
    assign rd_busy[i] = busy[ra] && !hit;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: expected {rd_data, rd_busy, any_busy, wr_count} vectors are queued then compared.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  opcode = 4'd1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        claim_en = 1'b0;
  logic [3:0]  claim_addr = '0;
  logic [7:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        any_busy;
  logic [15:0] wr_count;

  logic [82:0] obs;
  logic [82:0] exp_v;
  logic [82:0] sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .claim_en(claim_en), .claim_addr(claim_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .any_busy(any_busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  assign obs = {rd_data, rd_busy, any_busy, wr_count};

  function automatic logic [82:0] mk(input logic [31:0] d1, input logic [31:0] d0,
                                     input logic [1:0] b, input logic a, input logic [15:0] c);
    return {d1, d0, b, a, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    claim_en = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int a = 0; a < 16; a++) begin
      rd_addr = {a[3:0], a[3:0]};
      sb_q.push_back(mk(32'h0, 32'h0, 2'b00, 1'b0, 16'h0));
      #1;
      exp_v = sb_q.pop_front(); vectors++;
      if (obs !== exp_v) begin miscompares++; $display("FAIL reset_r%0d got %h expected %h", a, obs, exp_v); end
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_write_bypass();
    opcode = 4'b0001; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; rd_addr = {4'd0, 4'd5};
    sb_q.push_back(mk(32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 16'd0));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL write_bypass got %h expected %h", obs, exp_v); end
    tick();
    sb_q.push_back(mk(32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 16'd1));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL write_stored got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_inhibit();
    opcode = 4'b1111; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h11111111; rd_addr = {4'd0, 4'd5};
    sb_q.push_back(mk(32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 16'd1));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL inhibit_no_bypass got %h expected %h", obs, exp_v); end
    tick();
    claim_en = 1'b1; claim_addr = 4'd4;
    tick();
    rd_addr = {4'd4, 4'd5};
    sb_q.push_back(mk(32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 16'd1));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL inhibit_after_edge got %h expected %h", obs, exp_v); end
    opcode = 4'b0001;
  endtask

  task automatic test_claim();
    claim_en = 1'b1; claim_addr = 4'd3;
    tick();
    rd_addr = {4'd4, 4'd3};
    sb_q.push_back(mk(32'h0, 32'h0, 2'b01, 1'b1, 16'd1));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL claim_busy got %h expected %h", obs, exp_v); end
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h12;
    sb_q.push_back(mk(32'h0, 32'h12, 2'b00, 1'b1, 16'd1));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL claim_write_cycle got %h expected %h", obs, exp_v); end
    tick();
    sb_q.push_back(mk(32'h0, 32'h12, 2'b00, 1'b0, 16'd2));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL claim_cleared got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_same_cycle();
    claim_en = 1'b1; claim_addr = 4'd7; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h777;
    rd_addr = {4'd0, 4'd7};
    sb_q.push_back(mk(32'h0, 32'h777, 2'b00, 1'b0, 16'd2));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL same_addr_cycle got %h expected %h", obs, exp_v); end
    tick();
    rd_addr = {4'd7, 4'd7};
    sb_q.push_back(mk(32'h777, 32'h777, 2'b11, 1'b1, 16'd3));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL same_addr_set_wins got %h expected %h", obs, exp_v); end
    claim_en = 1'b1; claim_addr = 4'd2; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h999;
    rd_addr = {4'd9, 4'd2};
    sb_q.push_back(mk(32'h999, 32'h0, 2'b00, 1'b1, 16'd3));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL diff_addr_cycle got %h expected %h", obs, exp_v); end
    tick();
    sb_q.push_back(mk(32'h999, 32'h0, 2'b01, 1'b1, 16'd4));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL diff_addr_both got %h expected %h", obs, exp_v); end
    claim_en = 1'b1; claim_addr = 4'd7;
    tick();
    rd_addr = {4'd7, 4'd2};
    sb_q.push_back(mk(32'h777, 32'h0, 2'b11, 1'b1, 16'd4));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reclaim_busy got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_reg_zero();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFF; rd_addr = {4'd0, 4'd0};
`ifdef REG_ZERO_EN
    sb_q.push_back(mk(32'h0, 32'h0, 2'b00, 1'b1, 16'd4));
`else
    sb_q.push_back(mk(32'hFF, 32'hFF, 2'b00, 1'b1, 16'd4));
`endif
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL r0_bypass got %h expected %h", obs, exp_v); end
    tick();
    claim_en = 1'b1; claim_addr = 4'd0;
    tick();
`ifdef REG_ZERO_EN
    sb_q.push_back(mk(32'h0, 32'h0, 2'b00, 1'b1, 16'd5));
`else
    sb_q.push_back(mk(32'hFF, 32'hFF, 2'b11, 1'b1, 16'd5));
`endif
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL r0_after_edge got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid();
    #2;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hAAAA; claim_en = 1'b1; claim_addr = 4'd6;
    rd_addr = {4'd7, 4'd5};
    rst_n = 1'b0;
    sb_q.push_back(mk(32'h0, 32'h0, 2'b00, 1'b0, 16'd0));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_immediate got %h expected %h", obs, exp_v); end
    @(posedge clk);
    #1;
    sb_q.push_back(mk(32'h0, 32'h0, 2'b00, 1'b0, 16'd0));
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_held_edge got %h expected %h", obs, exp_v); end
    @(negedge clk);
    wr_en = 1'b0; claim_en = 1'b0; rst_n = 1'b1;
    rd_addr = {4'd6, 4'd5};
    sb_q.push_back(mk(32'h0, 32'h0, 2'b00, 1'b0, 16'd0));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL reset_released got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_wrap();
    opcode = 4'b0010; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h5A5A5A5A; rd_addr = {4'd0, 4'd1};
    repeat (65535) @(posedge clk);
    #1;
    sb_q.push_back(mk(32'h0, 32'h5A5A5A5A, 2'b00, 1'b0, 16'hFFFF));
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL wrap_ffff got %h expected %h", obs, exp_v); end
    @(posedge clk);
    #1;
    sb_q.push_back(mk(32'h0, 32'h5A5A5A5A, 2'b00, 1'b0, 16'h0000));
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL wrap_zero got %h expected %h", obs, exp_v); end
    wr_data = 32'hC0FFEE01;
    tick();
    sb_q.push_back(mk(32'h0, 32'hC0FFEE01, 2'b00, 1'b0, 16'h0001));
    #1;
    exp_v = sb_q.pop_front(); vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL wrap_65537 got %h expected %h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_inhibit();
    test_claim();
    test_same_cycle();
    test_reg_zero();
    test_reset_mid();
    test_wrap();
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
